uart_wb_master_bridge: RTL and testbench

//  Serial-to-Wishbone initiator. A host PC drives register accesses over a UART link; the bridge masters the SoC Wishbone bus.
//  It is the bus-initiating end of the same Wishbone/UART path our UART peripheral responds on, and is used for bring-up and debug.
//  It contains its own fixed-rate 8N1 receiver and transmitter, a command-frame parser FSM and a single-outstanding WB master.

---
 rtl/uart_wb_master_bridge.sv | 254 +++++++++++++++++++++++++
 tb/tb_uart_wb_master_bridge.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_master_bridge.sv
// UART (8N1, fixed CLK_DIV) command-frame parser driving a single-outstanding Wishbone master.
// Optional bus timeout with 0xEE error response: define UART_WB_BRIDGE_TIMEOUT_EN.
module uart_wb_master_bridge #(
  parameter int CLK_DIV = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ser_rx,
  output logic        ser_tx,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        busy
);

  if (CLK_DIV < 4 || TIMEOUT < 1) begin : g_param_check
    $error("uart_wb_master_bridge: CLK_DIV must be >= 4 and TIMEOUT >= 1");
  end

  localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] P_IDLE  = 3'd0;
  localparam logic [2:0] P_ADDR  = 3'd1;
  localparam logic [2:0] P_WDATA = 3'd2;
  localparam logic [2:0] P_BUS   = 3'd3;
  localparam logic [2:0] P_RESP  = 3'd4;

  logic        rx_s1_q, rx_s2_q;
  logic [1:0]  rx_state_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_shift_q;
  logic        rx_valid_q, rx_ferr_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_s1_q    <= ser_rx;
      rx_s2_q    <= rx_s1_q;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          rx_cnt_q <= '0;
          if (!rx_s2_q) rx_state_q <= RX_START;
        end
        RX_START: begin
          if (rx_cnt_q == HALF_M1) begin
            // a line that is high again at mid-start was only a glitch
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
          end else rx_cnt_q <= rx_cnt_q + 16'd1;
        end
        RX_DATA: begin
          if (rx_cnt_q == DIV_M1) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            else rx_bit_q <= rx_bit_q + 3'd1;
          end else rx_cnt_q <= rx_cnt_q + 16'd1;
        end
        default: begin
          if (rx_cnt_q == DIV_M1) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_IDLE;
            if (rx_s2_q) rx_valid_q <= 1'b1;
            else rx_ferr_q <= 1'b1;
          end else rx_cnt_q <= rx_cnt_q + 16'd1;
        end
      endcase
    end
  end

  logic        tx_active_q;
  logic [9:0]  tx_shift_q;
  logic [15:0] tx_cnt_q;
  logic [3:0]  tx_bit_q;
  logic        tx_last, tx_free, tx_load;
  logic [7:0]  tx_byte;

  // stop bit ends this cycle; a new byte may be loaded on the same edge
  assign tx_last = tx_active_q && (tx_cnt_q == DIV_M1) && (tx_bit_q == 4'd9);
  assign tx_free = !tx_active_q || tx_last;
  assign ser_tx  = tx_active_q ? tx_shift_q[0] : 1'b1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_active_q <= 1'b0;
      tx_shift_q  <= '1;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
    end else if (tx_load) begin
      tx_active_q <= 1'b1;
      tx_shift_q  <= {1'b1, tx_byte, 1'b0};
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
    end else if (tx_active_q) begin
      if (tx_cnt_q == DIV_M1) begin
        tx_cnt_q <= '0;
        if (tx_bit_q == 4'd9) tx_active_q <= 1'b0;
        else begin
          tx_bit_q   <= tx_bit_q + 4'd1;
          tx_shift_q <= {1'b1, tx_shift_q[9:1]};
        end
      end else tx_cnt_q <= tx_cnt_q + 16'd1;
    end
  end

  logic [2:0]  state_q, state_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic        is_wr_q, is_wr_d;
  logic [31:0] adr_q, adr_d, dat_q, dat_d, resp_q, resp_d;
  logic [2:0]  rleft_q, rleft_d;
  logic        cyc_q, cyc_d, we_q, we_d, busy_q, busy_d;
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
  logic [31:0] to_cnt_q, to_cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    is_wr_d = is_wr_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    resp_d  = resp_q;
    rleft_d = rleft_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    busy_d  = busy_q;
    tx_load = 1'b0;
    tx_byte = resp_q[7:0];
    case (state_q)
      P_IDLE: begin
        if (rx_valid_q && (rx_shift_q == 8'h01 || rx_shift_q == 8'h02)) begin
          is_wr_d = (rx_shift_q == 8'h01);
          bcnt_d  = '0;
          busy_d  = 1'b1;
          state_d = P_ADDR;
        end
      end
      P_ADDR, P_WDATA: begin
        if (rx_ferr_q) begin
          busy_d  = 1'b0;
          state_d = P_IDLE;
        end else if (rx_valid_q) begin
          if (state_q == P_ADDR) adr_d = {rx_shift_q, adr_q[31:8]};
          else dat_d = {rx_shift_q, dat_q[31:8]};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3)
            state_d = (state_q == P_ADDR && is_wr_q) ? P_WDATA : P_BUS;
        end
      end
      P_BUS: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = is_wr_q;
        end else if (wb_ack_i) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          resp_d  = is_wr_q ? 32'h0000_00A5 : wb_dat_i;
          rleft_d = is_wr_q ? 3'd1 : 3'd4;
          state_d = P_RESP;
        end
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
        if (to_cnt_q == 32'(TIMEOUT - 1) && !(cyc_q && wb_ack_i)) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          resp_d  = 32'h0000_00EE;
          rleft_d = 3'd1;
          state_d = P_RESP;
        end
`endif
      end
      P_RESP: begin
        if (tx_free) begin
          if (rleft_q != 3'd0) begin
            tx_load = 1'b1;
            resp_d  = resp_q >> 8;
            rleft_d = rleft_q - 3'd1;
          end else begin
            busy_d  = 1'b0;
            state_d = P_IDLE;
          end
        end
      end
      default: state_d = P_IDLE;
    endcase
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
    to_cnt_d = (state_q == P_BUS) ? to_cnt_q + 32'd1 : '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= P_IDLE;
      bcnt_q  <= '0;
      is_wr_q <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      resp_q  <= '0;
      rleft_q <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
      to_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      is_wr_q <= is_wr_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      resp_q  <= resp_d;
      rleft_q <= rleft_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
`endif
    end
  end

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_sel_o = {4{cyc_q}};
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_wb_master_bridge.sv
// Directed bench for uart_wb_master_bridge: frames in on ser_rx, WB slave model, ser_tx byte capture.
module tb_uart_wb_master_bridge;
  localparam int CLK_DIV = 8;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ser_rx = 1'b1;
  logic        ser_tx;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, busy;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;

  always #5 clk = ~clk;

  uart_wb_master_bridge #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn), .ser_rx(ser_rx), .ser_tx(ser_tx),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .busy(busy)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wishbone slave: acks after ack_wait stb cycles unless never_ack
  logic        never_ack = 1'b0;
  int          ack_wait = 0;
  int          stb_cnt = 0;
  logic [31:0] rdata = '0;
  always @(posedge clk) stb_cnt <= (wb_cyc_o && wb_stb_o) ? stb_cnt + 1 : 0;
  assign wb_ack_i = wb_cyc_o && wb_stb_o && !never_ack && (stb_cnt == ack_wait);
  assign wb_dat_i = rdata;

  int unsigned cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int          wb_n = 0, cyc_len = 0;
  logic        cyc_prev = 1'b0;
  logic [31:0] cap_adr = '0, cap_dat = '0;
  logic        cap_we = 1'b0;
  logic [3:0]  cap_sel = '0;
  always @(negedge clk) begin
    if (wb_cyc_o === 1'b1) begin
      if (!cyc_prev) begin
        wb_n++;
        cap_adr = wb_adr_o;
        cap_dat = wb_dat_o;
        cap_we  = wb_we_o;
        cap_sel = wb_sel_o;
        cyc_len = 0;
      end
      cyc_len++;
    end
    cyc_prev = (wb_cyc_o === 1'b1);
  end

  logic [7:0]  tx_q[$];
  int unsigned tx_t[$];
  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (ser_tx === 1'b0) begin
        tx_t.push_back(cyc_n);
        repeat (CLK_DIV / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (CLK_DIV) @(negedge clk);
          b[k] = ser_tx;
        end
        repeat (CLK_DIV) @(negedge clk);
        check("tx_stop_bit", {31'd0, ser_tx}, 32'd1);
        tx_q.push_back(b);
      end
    end
  end

  function automatic logic [31:0] txb(input int i);
    if (i < tx_q.size()) return {24'd0, tx_q[i]};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] txgap(input int i);
    if (i + 1 < tx_t.size()) return tx_t[i+1] - tx_t[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    ser_rx = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      ser_rx = b[k];
      repeat (CLK_DIV) @(negedge clk);
    end
    ser_rx = stop;
    repeat (CLK_DIV) @(negedge clk);
    ser_rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic wait_busy_low(input string tag, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_cyc_high(input string tag, input int budget);
    int n = 0;
    while (wb_cyc_o !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_cyc_rise"}, {31'd0, wb_cyc_o}, 32'd1);
  endtask

  task automatic clear_tx();
    tx_q.delete();
    tx_t.delete();
  endtask

  int base;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ser_tx", {31'd0, ser_tx}, 32'd1);
    check("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    check("rst_stb", {31'd0, wb_stb_o}, 32'd0);
    check("rst_we", {31'd0, wb_we_o}, 32'd0);
    check("rst_sel", {28'd0, wb_sel_o}, 32'd0);
    check("rst_adr", wb_adr_o, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    resetn = 1'b1;
    repeat (4) @(negedge clk);

    // write with 3 wait states
    ack_wait = 3;
    base = wb_n;
    clear_tx();
    send_byte(8'h01, 1'b1);
    check("t1_busy_rise", {31'd0, busy}, 32'd1);
    send_word(32'h3000_0010);
    send_word(32'hDEAD_BEEF);
    wait_busy_low("t1", 2000);
    check("t1_wb_count", wb_n - base, 32'd1);
    check("t1_adr", cap_adr, 32'h3000_0010);
    check("t1_dat", cap_dat, 32'hDEAD_BEEF);
    check("t1_we", {31'd0, cap_we}, 32'd1);
    check("t1_sel", {28'd0, cap_sel}, 32'hF);
    check("t1_cyc_len", cyc_len, 32'd4);
    check("t1_tx_count", tx_q.size(), 32'd1);
    check("t1_tx_byte", txb(0), 32'hA5);
    check("t1_cyc_idle", {31'd0, wb_cyc_o}, 32'd0);

    // zero-wait read, four back-to-back response bytes
    ack_wait = 0;
    rdata = 32'h1234_5678;
    base = wb_n;
    clear_tx();
    send_byte(8'h02, 1'b1);
    send_word(32'h2000_0004);
    wait_busy_low("t2", 2000);
    check("t2_wb_count", wb_n - base, 32'd1);
    check("t2_adr", cap_adr, 32'h2000_0004);
    check("t2_we", {31'd0, cap_we}, 32'd0);
    check("t2_cyc_len", cyc_len, 32'd1);
    check("t2_tx_count", tx_q.size(), 32'd4);
    check("t2_tx0", txb(0), 32'h78);
    check("t2_tx1", txb(1), 32'h56);
    check("t2_tx2", txb(2), 32'h34);
    check("t2_tx3", txb(3), 32'h12);
    for (int i = 0; i < 3; i++) check("t2_tx_spacing", txgap(i), 32'(10 * CLK_DIV));

    // junk command, then a framing-error byte, then a good read
    base = wb_n;
    clear_tx();
    send_byte(8'h55, 1'b1);
    repeat (20) @(negedge clk);
    check("t3_junk_busy", {31'd0, busy}, 32'd0);
    send_byte(8'h01, 1'b0);
    repeat (20) @(negedge clk);
    check("t3_ferr_busy", {31'd0, busy}, 32'd0);
    check("t3_no_wb", wb_n - base, 32'd0);
    check("t3_no_tx", tx_q.size(), 32'd0);
    rdata = 32'hCAFE_F00D;
    send_byte(8'h02, 1'b1);
    send_word(32'h2000_0008);
    wait_busy_low("t3", 2000);
    check("t3_wb_count", wb_n - base, 32'd1);
    check("t3_adr", cap_adr, 32'h2000_0008);
    check("t3_tx_count", tx_q.size(), 32'd4);
    check("t3_tx0", txb(0), 32'h0D);
    check("t3_tx3", txb(3), 32'hCA);

    // two-cycle glitch on an idle line
    base = wb_n;
    clear_tx();
    @(negedge clk);
    ser_rx = 1'b0;
    repeat (2) @(negedge clk);
    ser_rx = 1'b1;
    repeat (100) @(negedge clk);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_no_wb", wb_n - base, 32'd0);
    check("t4_no_tx", tx_q.size(), 32'd0);

    // slave never acks
    never_ack = 1'b1;
    clear_tx();
    send_byte(8'h02, 1'b1);
    send_word(32'h4000_0100);
    wait_cyc_high("t5", 300);
    check("t5_adr", wb_adr_o, 32'h4000_0100);
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
    wait_busy_low("t5", 2000);
    check("t5_cyc_len", cyc_len, 32'(TIMEOUT - 1));
    check("t5_cyc_idle", {31'd0, wb_cyc_o}, 32'd0);
    check("t5_tx_count", tx_q.size(), 32'd1);
    check("t5_tx_byte", txb(0), 32'hEE);
`else
    repeat (300) @(negedge clk);
    check("t5_cyc_held", {31'd0, wb_cyc_o}, 32'd1);
    check("t5_stb_held", {31'd0, wb_stb_o}, 32'd1);
    check("t5_busy_held", {31'd0, busy}, 32'd1);
    check("t5_no_tx", tx_q.size(), 32'd0);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
`endif

    // reset during a bus cycle
    send_byte(8'h02, 1'b1);
    send_word(32'h6000_0000);
    wait_cyc_high("t6a", 300);
    resetn = 1'b0;
    @(negedge clk);
    check("t6a_cyc", {31'd0, wb_cyc_o}, 32'd0);
    check("t6a_stb", {31'd0, wb_stb_o}, 32'd0);
    check("t6a_busy", {31'd0, busy}, 32'd0);
    check("t6a_ser_tx", {31'd0, ser_tx}, 32'd1);
    check("t6a_adr", wb_adr_o, 32'd0);
    resetn = 1'b1;
    never_ack = 1'b0;
    ack_wait = 0;

    // reset while the response byte is on the wire
    send_byte(8'h01, 1'b1);
    send_word(32'h7000_0000);
    send_word(32'h1122_3344);
    begin
      int n = 0;
      while (ser_tx !== 1'b0 && n < 400) begin
        @(negedge clk);
        n++;
      end
      check("t6b_tx_start", {31'd0, ser_tx}, 32'd0);
    end
    repeat (20) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("t6b_ser_tx", {31'd0, ser_tx}, 32'd1);
    check("t6b_busy", {31'd0, busy}, 32'd0);
    check("t6b_dat", wb_dat_o, 32'd0);
    resetn = 1'b1;
    repeat (100) @(negedge clk);
    clear_tx();

    // clean write after resets
    base = wb_n;
    send_byte(8'h01, 1'b1);
    send_word(32'h5000_0004);
    send_word(32'h0BAD_C0DE);
    wait_busy_low("t6c", 2000);
    check("t6c_wb_count", wb_n - base, 32'd1);
    check("t6c_adr", cap_adr, 32'h5000_0004);
    check("t6c_dat", cap_dat, 32'h0BAD_C0DE);
    check("t6c_we", {31'd0, cap_we}, 32'd1);
    check("t6c_tx_count", tx_q.size(), 32'd1);
    check("t6c_tx_byte", txb(0), 32'hA5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
